// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix operation sequencer.
package matrix_pkg;

    localparam int DIM_DEFAULT    = 2;
    localparam int ELEM_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ARMED = 3'd4
    } seq_state_e;

    // True for the opcodes this block knows how to execute
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Element-wise unsigned add/subtract with carry-out / borrow.
module matrix_elem_alu
    import matrix_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEFAULT
) (
    input  logic [2:0]        op,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] result,
    output logic              carry
);

    logic [ELEM_W:0] sum_ext;

    // One extra bit holds the add carry-out, or the borrow when a < b on subtract
    always_comb begin
        sum_ext = '0;
        if (op == OP_SUB) begin
            sum_ext = {1'b0, a} - {1'b0, b};
        end else begin
            sum_ext = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = sum_ext[ELEM_W-1:0];
    assign carry  = sum_ext[ELEM_W];

endmodule

// File: rtl/matrix_op_sequencer.sv
// Runs one element-wise add/sub over two DIM x DIM matrices per key press.
// Optional build macro: MATRIX_ENTER_CONFIRM_EN adds an ARMED state that
// waits for a rising edge of is_enter before the operation starts.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter  int DIM    = DIM_DEFAULT,
    parameter  int ELEM_W = ELEM_W_DEFAULT,
    localparam int N      = DIM * DIM,
    localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [2:0]        opcode,
    input  logic              is_op,
    input  logic              is_result,
    input  logic              is_enter,
    output logic [AW-1:0]     rd_addr,
    input  logic [ELEM_W-1:0] a_elem,
    input  logic [ELEM_W-1:0] b_elem,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [ELEM_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [2:0]        op_latched
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_RUN   = ST_RUN;
    localparam logic [2:0] S_FLUSH = ST_FLUSH;
    localparam logic [2:0] S_DONE  = ST_DONE;
`ifdef MATRIX_ENTER_CONFIRM_EN
    localparam logic [2:0] S_ARMED = ST_ARMED;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [2:0]        state;
    logic [AW-1:0]     idx;
    logic              go;
    logic              go_q;
    logic              go_rise;
    logic              latch;
    logic              vld_p1;
    logic [AW-1:0]     wr_addr_p1;
    logic [ELEM_W-1:0] wr_data_p1;
    logic [ELEM_W-1:0] alu_res;
    logic              alu_carry;

    assign go      = is_op & is_result & is_valid_op(opcode);
    assign go_rise = go & ~go_q;

`ifdef MATRIX_ENTER_CONFIRM_EN
    logic enter_q;
    logic enter_rise;

    assign enter_rise = is_enter & ~enter_q;
    // A new go edge latches the opcode from IDLE and re-latches while ARMED
    assign latch      = go_rise & ((state == S_IDLE) | (state == S_ARMED));

    // Edge detector for the enter key
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            enter_q <= 1'b0;
        end else begin
            enter_q <= is_enter;
        end
    end
`else
    logic unused_enter;

    assign unused_enter = is_enter;
    assign latch        = go_rise & (state == S_IDLE);
`endif

    // Edge detector for the start condition so a held key runs only once
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            go_q <= 1'b0;
        end else begin
            go_q <= go;
        end
    end

    // Sequencer FSM and element index counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            idx        <= '0;
            op_latched <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_rise) begin
                        op_latched <= opcode;
                        idx        <= '0;
`ifdef MATRIX_ENTER_CONFIRM_EN
                        state      <= S_ARMED;
`else
                        state      <= S_RUN;
`endif
                    end
                end
`ifdef MATRIX_ENTER_CONFIRM_EN
                S_ARMED: begin
                    if (enter_rise) begin
                        idx   <= '0;
                        state <= S_RUN;
                    end else if (go_rise) begin
                        op_latched <= opcode;
                    end
                end
`endif
                S_RUN: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd_addr = (state == S_RUN) ? idx : '0;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // --- stage p1: register-file data arrives, result is written back ---
    matrix_elem_alu #(
        .ELEM_W (ELEM_W)
    ) u_alu (
        .op     (op_latched),
        .a      (a_elem),
        .b      (b_elem),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // Write strobe and address trail the read address by one cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            vld_p1     <= (state == S_RUN);
            wr_addr_p1 <= rd_addr;
        end
    end

    // Keep the last written result so wr_data is stable between writes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_data_p1 <= '0;
        end else if (vld_p1) begin
            wr_data_p1 <= alu_res;
        end
    end

    // Sticky carry/borrow flag, cleared when a new operation is latched
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ovf <= 1'b0;
        end else if (latch) begin
            ovf <= 1'b0;
        end else if (vld_p1 && alu_carry) begin
            ovf <= 1'b1;
        end
    end

    assign wr_en   = vld_p1;
    assign wr_addr = wr_addr_p1;
    assign wr_data = vld_p1 ? alu_res : wr_data_p1;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed self-checking bench for matrix_op_sequencer (DIM=2, ELEM_W=8).
module tb_matrix_op_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [2:0] opcode;
    logic       is_op;
    logic       is_result;
    logic       is_enter;
    logic [1:0] rd_addr;
    logic [7:0] a_elem;
    logic [7:0] b_elem;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [2:0] op_latched;

    logic [7:0] mem_a [0:3];
    logic [7:0] mem_b [0:3];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    matrix_op_sequencer #(.DIM(2), .ELEM_W(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .opcode     (opcode),
        .is_op      (is_op),
        .is_result  (is_result),
        .is_enter   (is_enter),
        .rd_addr    (rd_addr),
        .a_elem     (a_elem),
        .b_elem     (b_elem),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .op_latched (op_latched)
    );

    always #5 clk = ~clk;

    // Register file model: one cycle read latency
    always @(posedge clk) begin
        a_elem <= mem_a[rd_addr];
        b_elem <= mem_b[rd_addr];
    end

    // Count write strobes and done pulses
    always @(negedge clk) begin
        if (wr_en) wr_cnt++;
        if (done)  done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = a[8*i +: 8];
            mem_b[i] = b[8*i +: 8];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_addr"},    32'(rd_addr),    32'd0);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_ovf"},        32'(ovf),        32'd0);
        check({tag, "_op_latched"}, 32'(op_latched), 32'd0);
    endtask

    // Leaves the bench in cycle 0 (the cycle in which the operation is triggered)
    task automatic start_op(input logic [2:0] op);
        opcode = op; is_op = 1'b1; is_result = 1'b1;
`ifdef MATRIX_ENTER_CONFIRM_EN
        step();
        is_op = 1'b0; is_result = 1'b0;
        step();
        is_enter = 1'b1;
`endif
    endtask

    // Runs one operation and checks every cycle against the fixed timeline
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] expw,
                          input logic exp_ovf, input logic [2:0] exp_op,
                          input bit hold, input int lock_cycle);
        int  w0;
        int  d0;
        logic eb;
        logic ew;
        w0 = wr_cnt;
        d0 = done_cnt;
        opcode = op; is_op = 1'b1; is_result = 1'b1;
`ifdef MATRIX_ENTER_CONFIRM_EN
        step();
        if (!hold) begin is_op = 1'b0; is_result = 1'b0; end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check({tag, "_armed_busy"},  32'(busy),  32'd1);
            check({tag, "_armed_wr_en"}, 32'(wr_en), 32'd0);
            step();
        end
        is_enter = 1'b1;
`endif
        for (int k = 0; k <= N + 3; k++) begin
            @(negedge clk);
            eb = (k >= 1) && (k <= N + 2);
`ifdef MATRIX_ENTER_CONFIRM_EN
            eb = (k <= N + 2);
`endif
            ew = (k >= 2) && (k <= N + 1);
            check({tag, "_busy"},  32'(busy),  32'(eb));
            check({tag, "_wr_en"}, 32'(wr_en), 32'(ew));
            if (ew && wr_en) begin
                check({tag, "_wr_addr"}, 32'(wr_addr), 32'(k - 2));
                check({tag, "_wr_data"}, 32'(wr_data), 32'(expw[8*(k-2) +: 8]));
            end
            check({tag, "_done"}, 32'(done), 32'(k == N + 2));
            step();
            if (k == 0) begin
                if (!hold) begin is_op = 1'b0; is_result = 1'b0; end
                is_enter = 1'b0;
            end
            if (k == lock_cycle - 1) begin opcode = 3'b010; is_op = 1'b1; is_result = 1'b1; end
            if (k == lock_cycle)     begin is_op = 1'b0; is_result = 1'b0; end
        end
        if (hold) begin
            repeat (12) step();
            is_op = 1'b0; is_result = 1'b0;
            repeat (3) step();
        end
        check({tag, "_ovf"},        32'(ovf),           32'(exp_ovf));
        check({tag, "_op_latched"}, 32'(op_latched),    32'(exp_op));
        check({tag, "_writes"},     32'(wr_cnt - w0),   32'd4);
        check({tag, "_dones"},      32'(done_cnt - d0), 32'd1);
        check({tag, "_idle"},       32'(busy),          32'd0);
    endtask

    initial begin
        int w0;
        nrst = 1'b0; opcode = 3'b000; is_op = 1'b0; is_result = 1'b0; is_enter = 1'b0;
        // A={1,2,3,4}, B={10,20,30,40}
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10});
        repeat (2) step();
        check_all_zero("reset");
        nrst = 1'b1;
        step();

        // Reset in the middle of an ADD
        start_op(3'b001);
        step();
        is_op = 1'b0; is_result = 1'b0; is_enter = 1'b0;
        step(); step();
        check("midrun_busy_before", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        step(); step();
        nrst = 1'b1;
        w0 = wr_cnt;
        repeat (8) step();
        check("after_reset_writes", 32'(wr_cnt - w0), 32'd0);
        check("after_reset_busy",   32'(busy),        32'd0);

        // ADD: 11,22,33,44
        run_op("add", 3'b001, {8'd44, 8'd33, 8'd22, 8'd11}, 1'b0, 3'b001, 1'b0, -1);

        // SUB with borrow: A={5,0,9,255}, B={3,1,9,0} -> 2,255,0,255
        load({8'd255, 8'd9, 8'd0, 8'd5}, {8'd0, 8'd9, 8'd1, 8'd3});
        run_op("sub", 3'b010, {8'd255, 8'd0, 8'd255, 8'd2}, 1'b1, 3'b010, 1'b0, -1);

        // ADD with carry: A={200,0,255,128}, B={100,0,1,127} -> 44,0,0,255
        load({8'd128, 8'd255, 8'd0, 8'd200}, {8'd127, 8'd1, 8'd0, 8'd100});
        run_op("add_carry", 3'b001, {8'd255, 8'd0, 8'd0, 8'd44}, 1'b1, 3'b001, 1'b0, -1);

        // Held key runs exactly once
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10});
        run_op("held", 3'b001, {8'd44, 8'd33, 8'd22, 8'd11}, 1'b0, 3'b001, 1'b1, -1);

        // SUB edge at cycle 3 of an ADD is ignored
        w0 = wr_cnt;
        run_op("lockout", 3'b001, {8'd44, 8'd33, 8'd22, 8'd11}, 1'b0, 3'b001, 1'b0, 3);
        repeat (6) step();
        check("lockout_no_second", 32'(wr_cnt - w0), 32'd4);

        // Invalid opcode never starts
        w0 = wr_cnt;
        opcode = 3'b100; is_op = 1'b1; is_result = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("invalid_busy", 32'(busy), 32'd0);
            step();
        end
        is_op = 1'b0; is_result = 1'b0;
        step();
        check("invalid_writes",     32'(wr_cnt - w0), 32'd0);
        check("invalid_op_latched", 32'(op_latched),  32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
Consumes the opcode and strobe levels from the keypad opcode encoder and runs one element-wise matrix operation (add or subtract) over two DIM x DIM operand matrices. Operands come from the matrix register file; results are written back to it. The block sits directly downstream of the opcode encoder and upstream of the result display logic. It converts held-key levels into a single operation per key press.

Parameters:
DIM, 2, matrix dimension (matrices are DIM x DIM; N = DIM*DIM elements)
ELEM_W, 8, element width in bits (unsigned)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
opcode  in  3  encoder opcode (001 add, 010 sub, others none)
is_op  in  1  encoder level: opcode key held
is_result  in  1  encoder level: result requested
is_enter  in  1  encoder level: enter key held
rd_addr  out  $clog2(N)  element index presented to the register file
a_elem  in  ELEM_W  matrix A element, valid one cycle after rd_addr
b_elem  in  ELEM_W  matrix B element, valid one cycle after rd_addr
wr_en  out  1  result element write strobe
wr_addr  out  $clog2(N)  result element index
wr_data  out  ELEM_W  result element
busy  out  1  operation in progress (state != IDLE)
done  out  1  one-cycle pulse after the last write
ovf  out  1  sticky carry/borrow flag for the last operation
op_latched  out  3  opcode of the current or last operation

Behaviour:
- Reset (async, nrst=0): state IDLE, index counter 0, edge register 0. All outputs 0: rd_addr, wr_en, wr_addr, wr_data, busy, done, ovf, op_latched. A reset mid-operation aborts it; no further writes are issued.
- Start condition: go = is_op & is_result & (opcode==ADD | opcode==SUB). Its value is registered each cycle. The block starts only on a rising edge of go, so a held key runs exactly one operation.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on a go rising edge. At that edge: op_latched <= opcode, ovf <= 0, idx <= 0. Invalid opcodes are ignored and the block stays in IDLE.
  - RUN: rd_addr = idx; idx increments each cycle. After idx = N-1 is issued, go to FLUSH.
  - Write pipeline, active in the cycle after each RUN cycle (including FLUSH): wr_en=1, wr_addr = previous rd_addr, wr_data = a_elem +/- b_elem modulo 2^ELEM_W.
  - FLUSH: issues the final write, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Timing, with start edge at cycle 0: rd_addr k is presented in cycle k+1; its write occurs in cycle k+2; done is high in cycle N+2; busy is high in cycles 1..N+2.
- Arithmetic is unsigned. ovf is set on any add carry-out or any sub borrow (a<b). ovf is sticky until the next start.
- Any go edges or opcode changes while busy are ignored. op_latched is stable from start until the next start.
- wr_data holds its last value when wr_en=0. rd_addr returns to 0 in IDLE.

Optional Feature:
MATRIX_ENTER_CONFIRM_EN
- Defined: adds an ARMED state. A go rising edge latches the opcode and moves IDLE -> ARMED. A rising edge of is_enter moves ARMED -> RUN. A go rising edge with a different valid opcode while ARMED re-latches the opcode. busy=1 in ARMED.
- Not defined: no ARMED state; IDLE -> RUN directly on a go rising edge, as above.

Decomposition:
- Package matrix_pkg holds:
  - the opcode enum: OP_NONE=3'b000, OP_ADD=3'b001, OP_SUB=3'b010;
  - the sequencer state enum;
  - the defaults for DIM and ELEM_W.
- Sub-module matrix_elem_alu: combinational; inputs op, a, b; outputs result[ELEM_W-1:0] and carry/borrow.

Test Plan:
1. Reset: hold nrst=0 mid-RUN -> all outputs 0 immediately; after release there are no wr_en pulses and busy=0.
2. ADD, DIM=2: A={1,2,3,4}, B={10,20,30,40}, pulse go -> wr_en at cycles 2..5 with addr 0..3 and data 11,22,33,44; done at cycle 6; ovf=0.
3. SUB with borrow: A={5,0,9,255}, B={3,1,9,0} -> data 2,255,0,255; ovf=1; op_latched=3'b010.
4. Held key: keep is_op=is_result=1 with opcode=001 for 20 cycles -> exactly one operation (4 writes, 1 done).
5. Busy lockout: a new SUB edge at cycle 3 of an ADD -> still ADD results; op_latched stays 001; no second operation.
6. Invalid opcode 3'b100 with is_op=is_result=1 -> state stays IDLE, busy=0, no writes. With MATRIX_ENTER_CONFIRM_EN: an ADD edge gives busy=1 with no writes until is_enter rises, and the first write comes 2 cycles after that edge.
